// File: rtl/scan_chain_sched.sv
// Round-robin scheduler that lends the single scan engine to NREQ requesters and gates the DUT clock around each scan.
// Optional watchdog on the STOP/RUN/RESUME waits is enabled by defining SCAN_SCHED_TIMEOUT_EN.
module scan_chain_sched #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned TMO_W  = 20
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       req_done,
  output logic [NREQ-1:0]       req_err,
  output logic                  dut_clk_stop,
  input  logic                  dut_clk_stopped,
  output logic                  scan_start,
  output logic [LEN_W-1:0]      scan_length,
  input  logic                  scan_done,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  // Handshakes: req is a level held by the requester until its req_done pulse, and gnt marks
  // ownership for the whole transaction; dut_clk_stop/dut_clk_stopped is a four-phase
  // request/acknowledge; scan_start and scan_done are single-cycle pulses.
  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_STOP, S_SETTLE, S_START, S_RUN, S_RESUME, S_CPL
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, winner_q, arb_idx;
  logic             arb_found;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, sel_len;
  logic [NREQ-1:0]  win_oh;

`ifdef SCAN_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // Scan from NREQ-1 down to 0 so the lowest offset from the pointer is written last and wins.
  always_comb begin
    int k;
    arb_found = 1'b0;
    arb_idx   = '0;
    k         = 0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      k = int'(ptr_q) + i;
      if (k >= int'(NREQ)) k = k - int'(NREQ);
      if (req[k[PW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = k[PW-1:0];
      end
    end
  end

  assign sel_len = req_len[arb_idx*LEN_W +: LEN_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (|req) state_d = S_ARB;
      S_ARB: begin
        if (!arb_found)           state_d = S_IDLE;
        else if (sel_len == '0)   state_d = S_CPL;
        else                      state_d = S_STOP;
      end
      S_STOP: begin
        if (dut_clk_stopped) begin
          state_d = S_SETTLE;
          cnt_d   = SW'(SETTLE - 1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_START;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_START:  state_d = S_RUN;
      S_RUN:    if (scan_done) state_d = S_RESUME;
      S_RESUME: if (!dut_clk_stopped) state_d = S_CPL;
      S_CPL:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
`ifdef SCAN_SCHED_TIMEOUT_EN
    // A stuck wait always releases the DUT clock via RESUME before completing with an error.
    err_d = (state_q == S_ARB) ? 1'b0 : err_q;
    if (&tmo_q && state_d == state_q) begin
      if (state_q == S_STOP || state_q == S_RUN) begin
        state_d = S_RESUME;
        err_d   = 1'b1;
      end else if (state_q == S_RESUME) begin
        state_d = S_CPL;
        err_d   = 1'b1;
      end
    end
    if (state_d != state_q)                                tmo_d = '0;
    else if (state_q inside {S_STOP, S_RUN, S_RESUME})    tmo_d = tmo_q + 1'b1;
    else                                                   tmo_d = tmo_q;
`endif
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      winner_q <= '0;
      len_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_ARB && arb_found) begin
        winner_q <= arb_idx;
        ptr_q    <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        len_q    <= sel_len;
      end
    end
  end

  assign win_oh       = NREQ'(1) << winner_q;
  assign gnt          = (state_q inside {S_IDLE, S_ARB}) ? '0 : win_oh;
  assign req_done     = (state_q == S_CPL) ? win_oh : '0;
  assign dut_clk_stop = state_q inside {S_STOP, S_SETTLE, S_START, S_RUN};
  assign scan_start   = (state_q == S_START);
  assign scan_length  = len_q;
  assign busy         = (state_q != S_IDLE);
  assign state_dbg    = state_q;

`ifdef SCAN_SCHED_TIMEOUT_EN
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign req_err = (state_q == S_CPL && err_q) ? win_oh : '0;
`else
  // TMO_W is always >= 1, so this is constant zero; it keeps one parameter list for both builds.
  assign req_err = {NREQ{TMO_W == 0}};
`endif

endmodule

// File: tb/tb_scan_chain_sched.sv
// Directed bench for scan_chain_sched: a clock-gate/scan-engine responder plus hand-computed expectations.
module tb_scan_chain_sched;

  localparam int NREQ   = 2;
  localparam int LEN_W  = 16;
  localparam int SETTLE = 4;
  localparam int TMO_W  = 8;

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       gnt, req_done, req_err;
  logic                  dut_clk_stop;
  logic                  dut_clk_stopped = 1'b0;
  logic                  scan_start;
  logic [LEN_W-1:0]      scan_length;
  logic                  scan_done = 1'b0;
  logic                  busy;
  logic [2:0]            state_dbg;

  scan_chain_sched #(
    .NREQ(NREQ), .LEN_W(LEN_W), .SETTLE(SETTLE), .TMO_W(TMO_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .req(req), .req_len(req_len),
    .gnt(gnt), .req_done(req_done), .req_err(req_err),
    .dut_clk_stop(dut_clk_stop), .dut_clk_stopped(dut_clk_stopped),
    .scan_start(scan_start), .scan_length(scan_length), .scan_done(scan_done),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 aclk = ~aclk;

  // ---------------- responder knobs (written by the main process only) ----------------
  logic ack_en     = 1'b1;
  int   ack_dly    = 1;
  int   done_dly   = 1;
  logic force_done = 1'b0;

  // ---------------- responder / monitor (only writer of the counters below) ----------------
  int               cyc = 0, n_start = 0, n_stop = 0, n_gnt_bad = 0;
  int               t_ack = 0, t_start = 0, ack_cnt = 0, done_cnt = 0;
  logic [NREQ-1:0]  gnt_prev = '0;
  logic [NREQ-1:0]  start_gnt [16];
  logic [LEN_W-1:0] start_len [16];

  always @(negedge aclk) begin
    cyc++;
    scan_done = force_done;
    if (aresetn) begin
      ack_cnt  = 0;
      done_cnt = 0;
    end
    if (dut_clk_stop) n_stop++;
    if (dut_clk_stop && !dut_clk_stopped) begin
      if (ack_en) begin
        ack_cnt++;
        if (ack_cnt >= ack_dly) begin
          dut_clk_stopped = 1'b1;
          ack_cnt         = 0;
          t_ack           = cyc;
        end
      end
    end else if (!dut_clk_stop) begin
      dut_clk_stopped = 1'b0;
      ack_cnt         = 0;
    end
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) scan_done = 1'b1;
    end
    if (scan_start) begin
      if (n_start < 16) begin
        start_gnt[n_start] = gnt;
        start_len[n_start] = scan_length;
      end
      n_start++;
      t_start  = cyc;
      done_cnt = done_dly;
    end
    if ((gnt & (gnt - 1'b1)) != '0) n_gnt_bad++;
    if (gnt_prev != '0 && gnt != '0 && gnt != gnt_prev) n_gnt_bad++;
    gnt_prev = gnt;
  end

  // ---------------- scoreboard ----------------
  int              n_cmp = 0;
  int              n_err = 0;
  logic [NREQ-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int budget, output int lat,
                           output logic [NREQ-1:0] dv, output logic [NREQ-1:0] ev);
    lat = 0;
    dv  = '0;
    ev  = '0;
    while (lat < budget) begin
      @(negedge aclk);
      lat++;
      if (req_done != '0) begin
        dv = req_done;
        ev = req_err;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_done: no req_done within %0d cycles", budget);
  endtask

  task automatic pulse_reset();
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int              lat, s0, st0, base;
    logic [NREQ-1:0] dv, ev, e;

    aresetn = 1'b1;
    req     = '0;
    req_len = '0;
    repeat (3) @(negedge aclk);

    // reset state
    chk("rst_gnt",      32'(gnt),          32'd0);
    chk("rst_req_done", 32'(req_done),     32'd0);
    chk("rst_req_err",  32'(req_err),      32'd0);
    chk("rst_clk_stop", 32'(dut_clk_stop), 32'd0);
    chk("rst_start",    32'(scan_start),   32'd0);
    chk("rst_length",   32'(scan_length),  32'd0);
    chk("rst_busy",     32'(busy),         32'd0);
    aresetn = 1'b0;
    @(negedge aclk);

    // single requester, len 40, ack in 3rd STOP cycle, done 100 cycles after start
    ack_dly  = 3;
    done_dly = 100;
    req_len[0 +: LEN_W] = 16'd40;
    s0  = n_start;
    st0 = n_stop;
    req = 2'b01;
    @(negedge aclk);
    chk("t1_arb_gnt",  32'(gnt),  32'd0);
    chk("t1_arb_busy", 32'(busy), 32'd1);
    @(negedge aclk);
    chk("t1_gnt",      32'(gnt),          32'd1);
    chk("t1_clk_stop", 32'(dut_clk_stop), 32'd1);
    wait_done(400, lat, dv, ev);
    chk("t1_latency",     32'(lat + 2),      32'd111);
    chk("t1_done",        32'(dv),           32'd1);
    chk("t1_err",         32'(ev),           32'd0);
    chk("t1_clk_release", 32'(dut_clk_stop), 32'd0);
    chk("t1_cpl_gnt",     32'(gnt),          32'd1);
    req = '0;
    @(negedge aclk);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_gnt",  32'(gnt),  32'd0);
    chk("t1_starts",    32'(n_start - s0), 32'd1);
    chk("t1_start_len", 32'(start_len[s0]), 32'd40);
    chk("t1_start_gnt", 32'(start_gnt[s0]), 32'd1);
    chk("t1_stop_cyc",  32'(n_stop - st0),  32'd108);

    // both requesters held, pointer back at 0: grants alternate 0,1,0,1
    pulse_reset();
    ack_dly  = 1;
    done_dly = 5;
    req_len[0 +: LEN_W]     = 16'd8;
    req_len[LEN_W +: LEN_W] = 16'd12;
    base = n_start;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done(200, lat, dv, ev);
      e = exp_q.pop_front();
      if (i == 3) req = '0;
      chk("t2_done",      32'(dv),                32'(e));
      chk("t2_starts",    32'(n_start - base),    32'(i + 1));
      chk("t2_start_gnt", 32'(start_gnt[base+i]), 32'(e));
      chk("t2_start_len", 32'(start_len[base+i]), (e == 2'b01) ? 32'd8 : 32'd12);
    end
    @(negedge aclk);
    chk("t2_gnt_onehot", 32'(n_gnt_bad), 32'd0);
    chk("t2_idle_busy",  32'(busy),      32'd0);

    // zero length: straight to completion, no clock stop, no scan
    req_len[LEN_W +: LEN_W] = 16'd0;
    s0  = n_start;
    st0 = n_stop;
    req = 2'b10;
    wait_done(10, lat, dv, ev);
    chk("t3_latency", 32'(lat),          32'd2);
    chk("t3_done",    32'(dv),           32'd2);
    chk("t3_gnt",     32'(gnt),          32'd2);
    chk("t3_clk",     32'(dut_clk_stop), 32'd0);
    req = '0;
    @(negedge aclk);
    chk("t3_starts",   32'(n_start - s0), 32'd0);
    chk("t3_stop_cyc", 32'(n_stop - st0), 32'd0);
    chk("t3_busy",     32'(busy),         32'd0);

    // settle timing, with a spurious scan_done injected before START
    ack_dly  = 2;
    done_dly = 3;
    req_len[0 +: LEN_W] = 16'd20;
    s0  = n_start;
    req = 2'b01;
    @(negedge aclk);
    @(negedge aclk);
    force_done = 1'b1;
    @(negedge aclk);
    force_done = 1'b0;
    wait_done(60, lat, dv, ev);
    chk("t4_settle",  32'(t_start - t_ack), 32'd5);
    chk("t4_latency", 32'(lat + 3),         32'd13);
    chk("t4_done",    32'(dv),              32'd1);
    chk("t4_starts",  32'(n_start - s0),    32'd1);
    req = '0;
    @(negedge aclk);

    // reset during RUN, then a fresh request on requester 1
    ack_dly  = 1;
    done_dly = 50;
    req_len[0 +: LEN_W] = 16'd30;
    s0  = n_start;
    req = 2'b01;
    lat = 0;
    while (n_start == s0 && lat < 30) begin
      @(negedge aclk);
      lat++;
    end
    chk("t5_started", 32'(n_start - s0), 32'd1);
    repeat (3) @(negedge aclk);
    chk("t5_in_run", 32'(state_dbg), 32'd5);
    aresetn = 1'b1;
    #1;
    chk("t5_rst_clk",  32'(dut_clk_stop), 32'd0);
    chk("t5_rst_gnt",  32'(gnt),          32'd0);
    chk("t5_rst_busy", 32'(busy),         32'd0);
    req = '0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    done_dly = 2;
    req_len[LEN_W +: LEN_W] = 16'd6;
    s0  = n_start;
    req = 2'b10;
    wait_done(60, lat, dv, ev);
    chk("t5_latency",   32'(lat),           32'd11);
    chk("t5_done",      32'(dv),            32'd2);
    chk("t5_starts",    32'(n_start - s0),  32'd1);
    chk("t5_start_len", 32'(start_len[s0]), 32'd6);
    req = '0;
    @(negedge aclk);

    // clock-stop acknowledge never arrives
    ack_en = 1'b0;
    req_len[0 +: LEN_W] = 16'd5;
    s0  = n_start;
    req = 2'b01;
`ifdef SCAN_SCHED_TIMEOUT_EN
    wait_done(400, lat, dv, ev);
    chk("t6_done", 32'(dv),           32'd1);
    chk("t6_err",  32'(ev),           32'd1);
    chk("t6_clk",  32'(dut_clk_stop), 32'd0);
    req = '0;
    @(negedge aclk);
`else
    repeat (300) @(negedge aclk);
    chk("t6_stuck_state", 32'(state_dbg),     32'd2);
    chk("t6_stuck_clk",   32'(dut_clk_stop),  32'd1);
    chk("t6_no_done",     32'(req_done),      32'd0);
    chk("t6_no_start",    32'(n_start - s0),  32'd0);
    req = '0;
    pulse_reset();
    chk("t6_rst_clk", 32'(dut_clk_stop), 32'd0);
`endif
    ack_en = 1'b1;

    chk("gnt_onehot_all", 32'(n_gnt_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
